// File: rtl/mult_pkg.sv
// mult_pkg: rounding-mode codes and Q-format range helpers shared by the multiplier blocks.
package mult_pkg;
    localparam logic [1:0] RND_TRUNC  = 2'b00;
    localparam logic [1:0] RND_HALFUP = 2'b01;
    localparam logic [1:0] RND_CONV   = 2'b10;

    function automatic longint q_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint q_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction
endpackage

// File: rtl/mult_round.sv
// mult_round: floor / half-up / convergent rounding of a full product back to Q format, with overflow.
// MULT_2IN_PIPE_SAT_EN clamps out-of-range results; otherwise they wrap to the low WIDTH bits.
module mult_round #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [2*WIDTH-1:0] p,
    input  logic        [1:0]         mode,
    output logic signed [WIDTH-1:0]   res,
    output logic                      ovf
);
    import mult_pkg::*;

    // one guard bit above the shifted product so the increment cannot wrap
    localparam int RW = 2*WIDTH - FRAC + 1;
    localparam logic signed [WIDTH-1:0] MAX = WIDTH'(q_max(WIDTH));
    localparam logic signed [WIDTH-1:0] MIN = WIDTH'(q_min(WIDTH));

    logic signed [RW-1:0] t, r;
    logic g, s, inc;

    always_comb begin
        t   = {p[2*WIDTH-1], p[2*WIDTH-1:FRAC]};
        g   = p[FRAC-1];
        s   = |p[FRAC-2:0];
        inc = mode == RND_TRUNC ? 1'b0 : mode == RND_CONV ? g & (s | t[0]) : g;
        r   = t + RW'(inc);
        ovf = !(&r[RW-1:WIDTH-1] || !(|r[RW-1:WIDTH-1]));
`ifdef MULT_2IN_PIPE_SAT_EN
        res = ovf ? (r[RW-1] ? MIN : MAX) : r[WIDTH-1:0];
`else
        res = r[WIDTH-1:0];
`endif
    end
endmodule

// File: rtl/mult_2in_pipe.sv
// mult_2in_pipe: pipelined signed Q(WIDTH-FRAC).FRAC multiplier with valid/ready flow control.
// Saturation on overflow is selected by defining MULT_2IN_PIPE_SAT_EN (applied inside mult_round).
module mult_2in_pipe #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 24,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  logic        [1:0]       i_rnd,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [WIDTH-1:0] o,
    output logic                    o_ovf
);
    localparam int PS = STAGES - 2;
    localparam int PW = 2*WIDTH;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("mult_2in_pipe: STAGES must be in 2..4");
    end

    logic [STAGES-1:0] v, v_in, load;
    logic signed [WIDTH-1:0] a_op, b_op, r;
    logic [1:0] m_op, m_p;
    logic signed [PW-1:0] p_q;
    logic r_ovf;

    // a slot can load whenever it, or any slot after it, has room to move
    always_comb begin
        load[STAGES-1] = !v[STAGES-1] || i_ready;
        for (int k = STAGES - 2; k >= 0; k--) load[k] = !v[k] || load[k+1];
    end

    assign v_in    = {v[STAGES-2:0], i_valid};
    assign o_ready = !rst && load[0];
    assign o_valid = v[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) v <= '0;
        else for (int k = 0; k < STAGES; k++) if (load[k]) v[k] <= v_in[k];
    end

    if (PS == 0) begin : g_direct
        assign a_op = i_a;
        assign b_op = i_b;
        assign m_op = i_rnd;
    end else begin : g_retime
        logic signed [WIDTH-1:0] a_q [PS];
        logic signed [WIDTH-1:0] b_q [PS];
        logic        [1:0]       m_q [PS];
        always_ff @(posedge clk) begin
            if (load[0]) begin
                a_q[0] <= i_a;
                b_q[0] <= i_b;
                m_q[0] <= i_rnd;
            end
            for (int k = 1; k < PS; k++) if (load[k]) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                m_q[k] <= m_q[k-1];
            end
        end
        assign a_op = a_q[PS-1];
        assign b_op = b_q[PS-1];
        assign m_op = m_q[PS-1];
    end

    always_ff @(posedge clk) begin
        if (load[PS]) begin
            p_q <= PW'(a_op) * PW'(b_op);
            m_p <= m_op;
        end
    end

    mult_round #(.WIDTH(WIDTH), .FRAC(FRAC)) u_round (
        .p    (p_q),
        .mode (m_p),
        .res  (r),
        .ovf  (r_ovf)
    );

    // result register only takes real beats so o stays 0 until the first result after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            o     <= '0;
            o_ovf <= 1'b0;
        end else if (load[STAGES-1] && v[STAGES-2]) begin
            o     <= r;
            o_ovf <= r_ovf;
        end
    end
endmodule
